// File: rtl/sdpram_fifo_pkg.sv
// Shared definitions for the sdpram_fifo show-ahead FIFO.
package sdpram_fifo_pkg;

  localparam int OUTBUF_DEPTH = 2;

  // Occupancy of the output buffer, encoded directly as its entry count
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } outbuf_state_e;

  // Width of the total-occupancy counter: RAM entries plus output buffer
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 2;
  endfunction

endpackage

// File: rtl/SimpleDualPortRAM.sv
// Simple dual-port RAM: port A writes, port B reads with a registered
// output of READ_LATENCY stages. In "common_clock" mode port B runs
// from clk_a.
module SimpleDualPortRAM #(
  parameter int    DATA_WIDTH    = 32,
  parameter int    DATA_DEPTH    = 256,
  parameter int    READ_LATENCY  = 1,
  parameter string CLOCKING_MODE = "common_clock"
) (
  input  logic                          clk_a,
  input  logic                          en_a_i,
  input  logic                          we_a_i,
  input  logic [$clog2(DATA_DEPTH)-1:0] addr_a_i,
  input  logic [DATA_WIDTH-1:0]         data_a_i,
  input  logic                          clk_b,
  input  logic                          rstb_n,
  input  logic                          en_b_i,
  input  logic [$clog2(DATA_DEPTH)-1:0] addr_b_i,
  output logic [DATA_WIDTH-1:0]         data_b_o
);

  localparam bit COMMON = (CLOCKING_MODE == "common_clock");

  logic                  rd_clk;
  logic [DATA_WIDTH-1:0] mem    [DATA_DEPTH];
  logic [DATA_WIDTH-1:0] pipe_q [READ_LATENCY];

  assign rd_clk = COMMON ? clk_a : clk_b;

  // Port A write
  always_ff @(posedge clk_a) begin
    if (en_a_i && we_a_i) mem[addr_a_i] <= data_a_i;
  end

  // Port B registered read and output pipeline
  always_ff @(posedge rd_clk or negedge rstb_n) begin
    if (!rstb_n) begin
      for (int unsigned i = 0; i < READ_LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      if (en_b_i) pipe_q[0] <= mem[addr_b_i];
      for (int unsigned i = 1; i < READ_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign data_b_o = pipe_q[READ_LATENCY-1];

endmodule

// File: rtl/sdpram_fifo_outbuf.sv
// Two-entry output buffer: slot0 is the head, slot1 the skid entry.
module sdpram_fifo_outbuf
  import sdpram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                load_i,
  input  logic [DATA_WIDTH-1:0]               data_i,
  input  logic                                pop_i,
  output logic                                valid_o,
  output logic [DATA_WIDTH-1:0]               data_o,
  output logic [$clog2(OUTBUF_DEPTH+1)-1:0]   cnt_o
);

  outbuf_state_e         state_q, state_d;
  logic [DATA_WIDTH-1:0] slot0_q, slot0_d;
  logic [DATA_WIDTH-1:0] slot1_q, slot1_d;

  // State and slot registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      slot0_q <= '0;
      slot1_q <= '0;
    end else begin
      state_q <= state_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
    end
  end

  // Load appends at the tail, pop advances slot1 into the head
  always_comb begin
    state_d = state_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    case (state_q)
      EMPTY: begin
        if (load_i) begin
          slot0_d = data_i;
          state_d = ONE;
        end
      end
      ONE: begin
        case ({load_i, pop_i})
          2'b11:   slot0_d = data_i;
          2'b10: begin
            slot1_d = data_i;
            state_d = TWO;
          end
          2'b01:   state_d = EMPTY;
          default: ;
        endcase
      end
      TWO: begin
        if (pop_i) begin
          slot0_d = slot1_q;
          if (load_i) slot1_d = data_i;
          else        state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  assign valid_o = (state_q != EMPTY);
  assign data_o  = slot0_q;
  assign cnt_o   = state_q;

endmodule

// File: rtl/sdpram_fifo.sv
// Show-ahead FIFO around SimpleDualPortRAM (read latency 1).
// Optional status outputs (count_o, almost_full_o) enabled by
// defining SDPRAM_FIFO_STATUS_EN; otherwise they are tied to 0.
module sdpram_fifo
  import sdpram_fifo_pkg::*;
#(
  parameter int DATA_DEPTH  = 256,
  parameter int DATA_WIDTH  = 32,
  parameter int AFULL_LEVEL = DATA_DEPTH - 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                wr_valid_i,
  output logic                                wr_ready_o,
  input  logic [DATA_WIDTH-1:0]               wr_data_i,
  output logic                                rd_valid_o,
  input  logic                                rd_ready_i,
  output logic [DATA_WIDTH-1:0]               rd_data_o,
  output logic [cnt_width(DATA_DEPTH)-1:0]    count_o,
  output logic                                almost_full_o
);

  localparam int AW = $clog2(DATA_DEPTH);
  localparam int CW = cnt_width(DATA_DEPTH);

  logic [AW-1:0]         wptr_q, wptr_d;
  logic [AW-1:0]         rptr_q, rptr_d;
  logic [AW:0]           ram_cnt_q, ram_cnt_d;
  logic                  inflight_q, inflight_d;
  logic                  wr_ready_q, wr_ready_d;
  logic                  push, pop, issue;
  logic [1:0]            buf_cnt;
  logic [2:0]            occ;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  ram_rst_n;

  // Pointer, RAM occupancy and write-ready registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      ram_cnt_q  <= '0;
      inflight_q <= 1'b0;
      wr_ready_q <= 1'b1;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      ram_cnt_q  <= ram_cnt_d;
      inflight_q <= inflight_d;
      wr_ready_q <= wr_ready_d;
    end
  end

  // Issue a RAM read whenever the buffer would still have room for it,
  // counting the read already in flight and a pop happening this cycle
  always_comb begin
    push       = wr_valid_i & wr_ready_q;
    pop        = rd_valid_o & rd_ready_i;
    occ        = {1'b0, buf_cnt} + {2'b00, inflight_q};
    issue      = (ram_cnt_q != '0) && (occ < (3'd2 + {2'b00, pop}));
    wptr_d     = wptr_q + AW'(push);
    rptr_d     = rptr_q + AW'(issue);
    ram_cnt_d  = ram_cnt_q + (AW+1)'(push) - (AW+1)'(issue);
    inflight_d = issue;
    wr_ready_d = (ram_cnt_d < (AW+1)'(DATA_DEPTH));
  end

  assign ram_rst_n  = ~rst;
  assign wr_ready_o = wr_ready_q;

  SimpleDualPortRAM #(
    .DATA_WIDTH    (DATA_WIDTH),
    .DATA_DEPTH    (DATA_DEPTH),
    .READ_LATENCY  (1),
    .CLOCKING_MODE ("common_clock")
  ) u_ram (
    .clk_a    (clk),
    .en_a_i   (push),
    .we_a_i   (push),
    .addr_a_i (wptr_q),
    .data_a_i (wr_data_i),
    .clk_b    (clk),
    .rstb_n   (ram_rst_n),
    .en_b_i   (issue),
    .addr_b_i (rptr_q),
    .data_b_o (ram_rdata)
  );

  sdpram_fifo_outbuf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_outbuf (
    .clk     (clk),
    .rst     (rst),
    .load_i  (inflight_q),
    .data_i  (ram_rdata),
    .pop_i   (pop),
    .valid_o (rd_valid_o),
    .data_o  (rd_data_o),
    .cnt_o   (buf_cnt)
  );

`ifdef SDPRAM_FIFO_STATUS_EN
  logic [CW-1:0] count_q, count_d;
  logic          afull_q, afull_d;

  // Total occupancy changes only on external push/pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      afull_q <= 1'b0;
    end else begin
      count_q <= count_d;
      afull_q <= afull_d;
    end
  end

  // Next occupancy and almost-full threshold
  always_comb begin
    count_d = count_q + CW'(push) - CW'(pop);
    afull_d = (count_d >= CW'(AFULL_LEVEL));
  end

  assign count_o       = count_q;
  assign almost_full_o = afull_q;
`else
  assign count_o       = '0;
  assign almost_full_o = 1'b0;
`endif

endmodule

// File: tb/tb_sdpram_fifo.sv
// Directed bench for sdpram_fifo with DATA_DEPTH=16.
module tb_sdpram_fifo;

  localparam int DEPTH = 16;
  localparam int DW    = 32;
  localparam int CW    = $clog2(DEPTH) + 2;
`ifdef SDPRAM_FIFO_STATUS_EN
  localparam bit STATUS = 1'b1;
`else
  localparam bit STATUS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_valid_i;
  logic          wr_ready_o;
  logic [DW-1:0] wr_data_i;
  logic          rd_valid_o;
  logic          rd_ready_i;
  logic [DW-1:0] rd_data_o;
  logic [CW-1:0] count_o;
  logic          almost_full_o;

  int unsigned   n_pass  = 0;
  int unsigned   n_total = 0;
  logic [DW-1:0] q[$];

  always #5 clk = ~clk;

  sdpram_fifo #(
    .DATA_DEPTH  (DEPTH),
    .DATA_WIDTH  (DW),
    .AFULL_LEVEL (DEPTH - 4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_valid_i    (wr_valid_i),
    .wr_ready_o    (wr_ready_o),
    .wr_data_i     (wr_data_i),
    .rd_valid_o    (rd_valid_o),
    .rd_ready_i    (rd_ready_i),
    .rd_data_o     (rd_data_o),
    .count_o       (count_o),
    .almost_full_o (almost_full_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One clock: check head against the model, update the model, advance,
  // then check stall stability and occupancy
  task automatic cycle();
    logic          stall;
    logic [DW-1:0] held;
    stall = rd_valid_o & ~rd_ready_i;
    held  = rd_data_o;
    if (rd_valid_o) begin
      if (q.size() == 0) chk("rd_spurious", 64'(rd_valid_o), 64'd0);
      else begin
        chk("rd_data", 64'(rd_data_o), 64'(q[0]));
        if (rd_ready_i) void'(q.pop_front());
      end
    end
    if (wr_valid_i && wr_ready_o) q.push_back(wr_data_i);
    step();
    if (stall) begin
      chk("stall_valid", 64'(rd_valid_o), 64'd1);
      chk("stall_data", 64'(rd_data_o), 64'(held));
    end
    chk("count", 64'(count_o), STATUS ? 64'(q.size()) : 64'd0);
    chk("afull", 64'(almost_full_o), 64'(STATUS && (q.size() >= DEPTH - 4)));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned   acc;
    int unsigned   bubbles;
    bit            found;

    rst = 1'b1; wr_valid_i = 1'b0; wr_data_i = '0; rd_ready_i = 1'b0;
    step(); step();
    chk("rst_wr_ready", 64'(wr_ready_o), 64'd1);
    chk("rst_rd_valid", 64'(rd_valid_o), 64'd0);
    chk("rst_rd_data",  64'(rd_data_o), 64'd0);
    chk("rst_count",    64'(count_o), 64'd0);
    chk("rst_afull",    64'(almost_full_o), 64'd0);
    rst = 1'b0;
    step();

    // Single word latency: push in cycle 0, head valid in cycle 3
    wr_valid_i = 1'b1; wr_data_i = 32'hA5A5_0001; rd_ready_i = 1'b1;
    step();
    wr_valid_i = 1'b0;
    chk("lat_c1_valid", 64'(rd_valid_o), 64'd0);
    chk("lat_c1_count", 64'(count_o), STATUS ? 64'd1 : 64'd0);
    step();
    chk("lat_c2_valid", 64'(rd_valid_o), 64'd0);
    step();
    chk("lat_c3_valid", 64'(rd_valid_o), 64'd1);
    chk("lat_c3_data",  64'(rd_data_o), 64'hA5A5_0001);
    step();
    chk("lat_c4_valid", 64'(rd_valid_o), 64'd0);
    chk("lat_c4_count", 64'(count_o), 64'd0);

    // Continuous stream of 1000 words with the consumer always ready
    bubbles = 0;
    rd_ready_i = 1'b1;
    for (int i = 0; i < 1010; i++) begin
      wr_valid_i = (i < 1000);
      wr_data_i  = DW'(i);
      if (i >= 3 && i <= 1002 && !rd_valid_o) bubbles++;
      cycle();
    end
    wr_valid_i = 1'b0;
    chk("stream_bubbles", 64'(bubbles), 64'd0);
    chk("stream_drained", 64'(q.size()), 64'd0);

    // Fill with the consumer stalled: 16 RAM entries plus 2 buffered
    acc = 0;
    rd_ready_i = 1'b0;
    for (int i = 0; i < 30; i++) begin
      wr_valid_i = 1'b1;
      wr_data_i  = 32'h100 + DW'(i);
      if (wr_ready_o) acc++;
      cycle();
    end
    wr_valid_i = 1'b0;
    chk("fill_accepted", 64'(acc), 64'd18);
    chk("fill_wr_ready", 64'(wr_ready_o), 64'd0);
    chk("fill_count",    64'(count_o), STATUS ? 64'd18 : 64'd0);
    chk("fill_afull",    64'(almost_full_o), STATUS ? 64'd1 : 64'd0);

    // Pop one from full: the refill read frees a RAM slot
    rd_ready_i = 1'b1;
    cycle();
    rd_ready_i = 1'b0;
    chk("pop_wr_ready", 64'(wr_ready_o), 64'd1);
    wr_valid_i = 1'b1; wr_data_i = 32'h200;
    cycle();
    wr_valid_i = 1'b0;
    chk("refill_wr_ready", 64'(wr_ready_o), 64'd0);
    rd_ready_i = 1'b1;
    for (int i = 0; i < 40 && q.size() != 0; i++) cycle();
    step();
    chk("wrap_drained", 64'(q.size()), 64'd0);
    chk("wrap_rd_valid", 64'(rd_valid_o), 64'd0);

    // Random traffic against the queue model
    for (int i = 0; i < 4000; i++) begin
      wr_valid_i = ($urandom_range(0, 3) != 0);
      rd_ready_i = ($urandom_range(0, 1) != 0);
      wr_data_i  = $urandom;
      cycle();
    end
    wr_valid_i = 1'b0; rd_ready_i = 1'b1;
    for (int i = 0; i < 40 && q.size() != 0; i++) cycle();
    chk("rand_drained", 64'(q.size()), 64'd0);

    // Asynchronous reset with 5 held and a read in flight
    rd_ready_i = 1'b0; wr_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_data_i = 32'h300 + DW'(i);
      cycle();
    end
    wr_valid_i = 1'b0; rd_ready_i = 1'b1;
    cycle();
    rd_ready_i = 1'b0;
    rst = 1'b1;
    #1;
    chk("arst_wr_ready", 64'(wr_ready_o), 64'd1);
    chk("arst_rd_valid", 64'(rd_valid_o), 64'd0);
    chk("arst_rd_data",  64'(rd_data_o), 64'd0);
    chk("arst_count",    64'(count_o), 64'd0);
    chk("arst_afull",    64'(almost_full_o), 64'd0);
    q.delete();
    step(); step();
    rst = 1'b0;
    step();
    chk("arst_hold_valid", 64'(rd_valid_o), 64'd0);
    wr_valid_i = 1'b1; wr_data_i = 32'h1234; rd_ready_i = 1'b1;
    found = 1'b0;
    cycle();
    wr_valid_i = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (rd_valid_o) begin
        found = 1'b1;
        chk("arst_first_word", 64'(rd_data_o), 64'h1234);
      end
      cycle();
    end
    chk("arst_first_seen", 64'(found), 64'd1);
    chk("arst_drained", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
